// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_COUNT,
    S_RECV,
    S_WRITE,
    S_HOLD,
    S_RUN
  } state_t;

  localparam int unsigned BIDX_W = 2;
  localparam int unsigned CNT_W  = 9;

  // A count byte of 0 encodes a full 256-word image.
  function automatic logic [CNT_W-1:0] word_count(input logic [7:0] n);
    return (n == 8'd0) ? CNT_W'(256) : CNT_W'(n);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // master: the loader (sinks bytes, drives the memory bus)
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );

  // slave: byte source and instruction memory
  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs big-endian bytes into a 32-bit word with a 2-bit byte index.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic        shift_en,
  input  logic        clr,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last_byte
);
  logic [23:0]       shreg;
  logic [BIDX_W-1:0] idx;

  // Only the three earlier bytes are stored; the fourth is taken live from
  // din so the full word is ready in the same cycle as the final transfer.
  assign word      = {shreg, din};
  assign last_byte = (idx == '1);

  // Shift register and byte index.
  always_ff @(posedge clk) begin
    if (!rstd || clr) begin
      shreg <= '0;
      idx   <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[15:0], din};
      idx   <= idx + 1'b1;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Loads a byte-streamed program image into instruction memory and holds the
// processor in reset until the image is complete.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned HOLD    = 4
) (
  input  logic          clk,
  input  logic          rstd,
  prog_loader_if.master bus,
  input  logic          load_req,
  output logic          cpu_rstd,
  output logic          done,
  output logic          err
);
  localparam int unsigned TW = $clog2(TIMEOUT + HOLD + 1);

  state_t            state, next_state;
  logic [7:0]        count_q;
  logic [ADDR_W-1:0] word_idx;
  logic [TW-1:0]     timer;
  logic              xfer, shift_en, last_byte, abort, restart, last_word;
  logic [31:0]       word;

  assign bus.byte_ready = rstd && (state == S_COUNT || state == S_RECV);
  assign xfer           = bus.byte_valid && bus.byte_ready;
  assign shift_en       = xfer && (state == S_RECV);
  assign restart        = (state == S_RUN) && load_req;
  assign last_word      = (CNT_W'(word_idx) + CNT_W'(1)) == word_count(count_q);

  byte_packer u_packer (
    .clk       (clk),
    .rstd      (rstd),
    .shift_en  (shift_en),
    .clr       (abort || restart || (state == S_COUNT && xfer)),
    .din       (bus.byte_data),
    .word      (word),
    .last_byte (last_byte)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstd) state <= S_COUNT;
    else       state <= next_state;
  end

  // Next-state logic and timeout abort detection.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      S_COUNT: if (xfer) next_state = S_RECV;
      S_RECV: begin
        if (xfer && last_byte) begin
          next_state = S_WRITE;
        end else if (!xfer && timer == TW'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          next_state = S_COUNT;
        end
      end
      S_WRITE: next_state = last_word ? S_HOLD : S_RECV;
      S_HOLD:  if (timer == TW'(HOLD - 1)) next_state = S_RUN;
      S_RUN:   if (load_req) next_state = S_COUNT;
      default: next_state = S_COUNT;
    endcase
  end

  // Shared timer: inter-byte idle counter in S_RECV, hold counter in S_HOLD.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      timer <= '0;
    end else begin
      case (state)
        S_RECV:  timer <= (xfer || abort) ? '0 : timer + 1'b1;
        S_HOLD:  timer <= timer + 1'b1;
        default: timer <= '0;
      endcase
    end
  end

  // Word count latch and word index.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      count_q  <= '0;
      word_idx <= '0;
    end else begin
      if (state == S_COUNT && xfer) count_q <= bus.byte_data;
      if (state == S_WRITE)         word_idx <= word_idx + 1'b1;
      else if (abort || restart)    word_idx <= '0;
    end
  end

  // Registered outputs; cpu_rstd/done follow the state being entered.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_rstd     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.im_we <= shift_en && last_byte;
      if (shift_en && last_byte) begin
        bus.im_addr  <= word_idx;
        bus.im_wdata <= word;
      end
      cpu_rstd <= (next_state == S_RUN);
      done     <= (next_state == S_RUN);
      if (abort)                    err <= 1'b1;
      else if (state == S_COUNT && xfer) err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: random images, expected writes queued at
// issue time, monitor compares every im_we pulse.
module tb_prog_loader;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned HOLD    = 4;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstd, load_req, cpu_rstd, done, err;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
    .clk      (clk),
    .rstd     (rstd),
    .bus      (bus),
    .load_req (load_req),
    .cpu_rstd (cpu_rstd),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  // Monitor: every write must match the next expected word.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, bus.im_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, bus.im_addr}, {24'd0, e.addr});
        check("wr_data", bus.im_wdata, e.data);
      end
      check("done_low_during_write", {31'd0, done}, 32'd0);
    end
  end

  // Sends one byte after 'gap' idle cycles; returns at the negedge after the
  // transfer edge. Entered and left at a negedge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned waited = 0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 2000) begin
        check("byte_ready_timeout", 32'd0, 32'd1);
        bus.byte_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  function automatic int unsigned pick_gap(input int gap_mode);
    return (gap_mode < 0) ? $urandom_range(2, 0) : int'(gap_mode);
  endfunction

  // Full load of n_words random words (1..256); checks write cycle, err
  // clearing and the HOLD+1 release delay.
  task automatic load_image(input int unsigned n_words, input int gap_mode,
                            input logic [31:0] first_word, input logic use_first);
    logic [31:0] img[];
    img = new[n_words];
    for (int unsigned w = 0; w < n_words; w++) begin
      img[w] = (w == 0 && use_first) ? first_word : $urandom;
      exp_q.push_back('{addr: 8'(w), data: img[w]});
    end
    send_byte(8'(n_words), pick_gap(gap_mode));
    check("err_cleared_by_count", {31'd0, err}, 32'd0);
    for (int unsigned w = 0; w < n_words; w++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        logic [31:0] cur;
        cur = img[w];
        send_byte(cur[31 - 8*k -: 8], pick_gap(gap_mode));
      end
      check("im_we_after_4th", {31'd0, bus.im_we}, 32'd1);
      check("ready_low_in_write", {31'd0, bus.byte_ready}, 32'd0);
    end
    repeat (HOLD) @(negedge clk);
    check("cpu_rstd_still_low", {31'd0, cpu_rstd}, 32'd0);
    check("done_still_low", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("cpu_rstd_released", {31'd0, cpu_rstd}, 32'd1);
    check("done_set", {31'd0, done}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    load_req       = 1'b0;
    rstd           = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("rst_im_we", {31'd0, bus.im_we}, 32'd0);
    check("rst_im_addr", {24'd0, bus.im_addr}, 32'd0);
    check("rst_im_wdata", bus.im_wdata, 32'd0);
    check("rst_cpu_rstd", {31'd0, cpu_rstd}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rstd = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, bus.byte_ready}, 32'd1);

    // 1: single word 24010001, back-to-back bytes
    load_image(1, 0, 32'h2401_0001, 1'b1);

    // 4a: load_req in S_RUN restarts loading
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("reload_cpu_rstd", {31'd0, cpu_rstd}, 32'd0);
    check("reload_done", {31'd0, done}, 32'd0);
    check("reload_ready", {31'd0, bus.byte_ready}, 32'd1);

    // 2: three words, byte_valid toggling every other cycle
    load_image(3, 1, 32'd0, 1'b0);

    // 4b: load_req during S_RECV is ignored
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    begin
      logic [31:0] w0, w1;
      w0 = $urandom;
      w1 = $urandom;
      exp_q.push_back('{addr: 8'd0, data: w0});
      exp_q.push_back('{addr: 8'd1, data: w1});
      send_byte(8'd2, 0);
      send_byte(w0[31:24], 0);
      load_req = 1'b1;
      send_byte(w0[23:16], 1);
      send_byte(w0[15:8], 0);
      send_byte(w0[7:0], 2);
      send_byte(w1[31:24], 0);
      load_req = 1'b0;
      send_byte(w1[23:16], 0);
      send_byte(w1[15:8], 1);
      send_byte(w1[7:0], 0);
      repeat (HOLD + 1) @(negedge clk);
      check("recv_load_req_ignored_done", {31'd0, done}, 32'd1);
      check("recv_load_req_queue", exp_q.size(), 32'd0);
    end

    // 3: timeout after 6 of 8 data bytes
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    begin
      logic [31:0] w0;
      w0 = $urandom;
      exp_q.push_back('{addr: 8'd0, data: w0});
      send_byte(8'd2, 0);
      for (int unsigned k = 0; k < 4; k++) send_byte(w0[31 - 8*k -: 8], $urandom_range(2, 0));
      send_byte(8'hA5, 1);
      send_byte(8'h5A, 0);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("err_before_timeout", {31'd0, err}, 32'd0);
      @(negedge clk);
      check("err_after_timeout", {31'd0, err}, 32'd1);
      check("ready_in_count", {31'd0, bus.byte_ready}, 32'd1);
      check("timeout_cpu_rstd", {31'd0, cpu_rstd}, 32'd0);
      check("timeout_queue", exp_q.size(), 32'd0);
    end
    load_image(2, -1, 32'd0, 1'b0);

    // 5: reset after two data bytes of word 0
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    send_byte(8'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rstd = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("midrst_im_we", {31'd0, bus.im_we}, 32'd0);
    rstd = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus.byte_ready}, 32'd1);
    check("post_rst_cpu_rstd", {31'd0, cpu_rstd}, 32'd0);
    check("post_rst_im_we", {31'd0, bus.im_we}, 32'd0);
    load_image(2, -1, 32'd0, 1'b0);

    // 6: count 0 -> 256 words, addresses 0..255
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    load_image(256, 0, 32'd0, 1'b0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
